// File: rtl/shot_entry.sv
// Battleship keyboard front end: turns PS/2 set-2 make codes into a row/column shot,
// hands it to the decider over valid/ready and tracks whose turn it is.
module shot_entry #(
    parameter int          BOARD_SIZE = 10,
    parameter logic [7:0]  ENTER_CODE = 8'h5A,
    parameter logic [7:0]  BKSP_CODE  = 8'h66
) (
    input  logic        clock27,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic        shot_ready,
    output logic        shot_valid,
    output logic [3:0]  shot_row,
    output logic [3:0]  shot_col,
    output logic        shot_player,
    output logic        player_turn,
    output logic [3:0]  pend_row,
    output logic [3:0]  pend_col,
    output logic [1:0]  pend_flags,
    output logic        key_err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HAVE_ROW  = 2'd1;
    localparam logic [1:0] HAVE_BOTH = 2'd2;
    localparam logic [1:0] SEND      = 2'd3;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    logic [1:0] state;
    logic       break_skip;
    logic       ext;

    logic       letter_hit;
    logic [3:0] letter_idx;
    logic       digit_hit;
    logic [3:0] digit_idx;

    logic       byte_live;
    logic       ev_letter;
    logic       ev_digit;
    logic       ev_enter;
    logic       ev_bksp;

    always_comb begin
        letter_hit = 1'b1;
        letter_idx = 4'd0;
        case (key_code)
            8'h1C:   letter_idx = 4'd0;
            8'h32:   letter_idx = 4'd1;
            8'h21:   letter_idx = 4'd2;
            8'h23:   letter_idx = 4'd3;
            8'h24:   letter_idx = 4'd4;
            8'h2B:   letter_idx = 4'd5;
            8'h34:   letter_idx = 4'd6;
            8'h33:   letter_idx = 4'd7;
            8'h43:   letter_idx = 4'd8;
            8'h3B:   letter_idx = 4'd9;
            default: letter_hit = 1'b0;
        endcase
    end

    always_comb begin
        digit_hit = 1'b1;
        digit_idx = 4'd0;
        case (key_code)
            8'h45:   digit_idx = 4'd0;
            8'h16:   digit_idx = 4'd1;
            8'h1E:   digit_idx = 4'd2;
            8'h26:   digit_idx = 4'd3;
            8'h25:   digit_idx = 4'd4;
            8'h2E:   digit_idx = 4'd5;
            8'h36:   digit_idx = 4'd6;
            8'h3D:   digit_idx = 4'd7;
            8'h3E:   digit_idx = 4'd8;
            8'h46:   digit_idx = 4'd9;
            default: digit_hit = 1'b0;
        endcase
    end

    // A byte reaches the FSM only if it is not a prefix and not swallowed by one;
    // after E0 the only byte that survives is keypad Enter.
    always_comb begin
        byte_live = 1'b0;
        ev_enter  = 1'b0;
        if (key_valid && !break_skip && key_code != BREAK_CODE && key_code != EXT_CODE) begin
            if (ext)
                ev_enter = (key_code == ENTER_CODE);
            else
                byte_live = 1'b1;
        end
        ev_letter = byte_live && letter_hit && (int'(letter_idx) < BOARD_SIZE);
        ev_digit  = byte_live && digit_hit && (int'(digit_idx) < BOARD_SIZE);
        ev_bksp   = byte_live && (key_code == BKSP_CODE);
        ev_enter  = ev_enter || (byte_live && key_code == ENTER_CODE);
    end

    always_ff @(posedge clock27) begin
        if (reset) begin
            break_skip <= 1'b0;
            ext        <= 1'b0;
        end else if (key_valid) begin
            if (break_skip) begin
                break_skip <= 1'b0;
                ext        <= 1'b0;
            end else if (key_code == BREAK_CODE) begin
                break_skip <= 1'b1;
            end else if (key_code == EXT_CODE) begin
                ext <= 1'b1;
            end else begin
                ext <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock27) begin
        if (reset) begin
            state       <= IDLE;
            pend_row    <= 4'd0;
            pend_col    <= 4'd0;
            shot_row    <= 4'd0;
            shot_col    <= 4'd0;
            shot_player <= 1'b0;
            player_turn <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_letter) begin
                        pend_row <= letter_idx;
                        state    <= HAVE_ROW;
                    end else if (ev_digit || ev_enter) begin
                        key_err <= 1'b1;
                    end
                end
                HAVE_ROW: begin
                    if (ev_letter) begin
                        pend_row <= letter_idx;
                    end else if (ev_digit) begin
                        pend_col <= digit_idx;
                        state    <= HAVE_BOTH;
                    end else if (ev_enter) begin
                        key_err <= 1'b1;
                    end else if (ev_bksp) begin
                        pend_row <= 4'd0;
                        state    <= IDLE;
                    end
                end
                HAVE_BOTH: begin
                    if (ev_letter) begin
                        pend_row <= letter_idx;
                        pend_col <= 4'd0;
                        state    <= HAVE_ROW;
                    end else if (ev_digit) begin
                        pend_col <= digit_idx;
                    end else if (ev_bksp) begin
                        pend_col <= 4'd0;
                        state    <= HAVE_ROW;
                    end else if (ev_enter) begin
                        shot_row    <= pend_row;
                        shot_col    <= pend_col;
                        shot_player <= player_turn;
                        state       <= SEND;
                    end
                end
                default: begin
                    // Keys arriving while a shot is outstanding never reach the FSM.
                    if (shot_ready) begin
                        player_turn <= ~player_turn;
                        pend_row    <= 4'd0;
                        pend_col    <= 4'd0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign shot_valid = (state == SEND);

    always_comb begin
        case (state)
            IDLE:     pend_flags = 2'b00;
            HAVE_ROW: pend_flags = 2'b01;
            default:  pend_flags = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_shot_entry.sv
// Scoreboard bench for shot_entry: a rule-level keyboard model predicts pending
// fields and shots; a negedge monitor checks every handshake transfer.
module tb_shot_entry;

    logic        clock27 = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        shot_ready;
    logic        shot_valid;
    logic [3:0]  shot_row;
    logic [3:0]  shot_col;
    logic        shot_player;
    logic        player_turn;
    logic [3:0]  pend_row;
    logic [3:0]  pend_col;
    logic [1:0]  pend_flags;
    logic        key_err;

    shot_entry dut (
        .clock27     (clock27),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .shot_ready  (shot_ready),
        .shot_valid  (shot_valid),
        .shot_row    (shot_row),
        .shot_col    (shot_col),
        .shot_player (shot_player),
        .player_turn (player_turn),
        .pend_row    (pend_row),
        .pend_col    (pend_col),
        .pend_flags  (pend_flags),
        .key_err     (key_err)
    );

    always #5 clock27 = ~clock27;

    typedef struct {
        int row;
        int col;
        int player;
    } shot_t;

    shot_t expq[$];
    shot_t got;
    int    errors    = 0;
    int    checks    = 0;
    int    transfers = 0;
    int    expected_transfers = 0;

    // Reference model: what the player has typed, kept as plain flags and numbers.
    bit m_have_row, m_have_col, m_pending, m_turn, m_err, m_brk, m_ext;
    int m_row, m_col;

    logic [7:0] letter_codes[10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool[14]         = '{8'h1C, 8'h3B, 8'h21, 8'h45, 8'h46, 8'h16, 8'h5A, 8'h5A, 8'h66,
                                     8'hF0, 8'hE0, 8'h29, 8'h33, 8'h3E};

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelClear();
        m_have_row = 0; m_have_col = 0; m_pending = 0; m_turn = 0;
        m_err = 0; m_brk = 0; m_ext = 0; m_row = 0; m_col = 0;
    endtask

    // kind: 0 nothing, 1 letter, 2 digit, 3 enter, 4 backspace
    task automatic modelStep(input bit kv, input logic [7:0] code, input bit rdy);
        bit    was_pending = m_pending;
        int    kind = 0;
        int    idx = 0;
        shot_t s;
        m_err = 0;
        if (m_pending && rdy) begin
            m_turn = !m_turn;
            m_pending = 0;
            m_have_row = 0; m_have_col = 0;
            m_row = 0; m_col = 0;
        end
        if (kv) begin
            if (m_brk) begin
                m_brk = 0; m_ext = 0;
            end else if (code == 8'hF0) begin
                m_brk = 1;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else if (m_ext) begin
                m_ext = 0;
                if (code == 8'h5A) kind = 3;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (letter_codes[i] == code) begin kind = 1; idx = i; end
                    if (digit_codes[i] == code) begin kind = 2; idx = i; end
                end
                if (code == 8'h5A) kind = 3;
                if (code == 8'h66) kind = 4;
            end
        end
        if (!was_pending) begin
            case (kind)
                1: begin
                    m_row = idx; m_have_row = 1;
                    if (m_have_col) begin m_have_col = 0; m_col = 0; end
                end
                2: begin
                    if (!m_have_row) m_err = 1;
                    else begin m_col = idx; m_have_col = 1; end
                end
                3: begin
                    if (!m_have_col) begin
                        if (!m_have_row || !m_have_col) m_err = 1;
                    end else begin
                        s.row = m_row; s.col = m_col; s.player = int'(m_turn);
                        expq.push_back(s);
                        expected_transfers++;
                        m_pending = 1;
                    end
                end
                4: begin
                    if (m_have_col) begin m_have_col = 0; m_col = 0; end
                    else if (m_have_row) begin m_have_row = 0; m_row = 0; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput();
        check("shot_valid", int'(shot_valid), int'(m_pending));
        check("player_turn", int'(player_turn), int'(m_turn));
        check("pend_row", int'(pend_row), m_row);
        check("pend_col", int'(pend_col), m_col);
        check("pend_flags", int'(pend_flags), int'({m_have_col, m_have_row}));
        check("key_err", int'(key_err), int'(m_err));
    endtask

    task automatic applyStimulus(input bit kv, input logic [7:0] code, input bit rdy);
        key_valid  = kv;
        key_code   = code;
        shot_ready = rdy;
        modelStep(kv, code, rdy);
        @(posedge clock27);
        #1;
        checkOutput();
    endtask

    task automatic sendKey(input logic [7:0] code, input bit rdy);
        applyStimulus(1'b1, code, rdy);
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy);
    endtask

    task automatic doReset(input bit rdy);
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 8'h00;
        shot_ready = rdy;
        @(posedge clock27);
        #1;
        reset = 1'b0;
        modelClear();
        expq.delete();
        checkOutput();
        check("reset shot_row", int'(shot_row), 0);
        check("reset shot_col", int'(shot_col), 0);
        check("reset shot_player", int'(shot_player), 0);
    endtask

    // A transfer happens on the coming edge whenever valid and ready are both high here.
    always @(negedge clock27) begin
        if (!reset && shot_valid && shot_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer: got row=%0d col=%0d, expected no shot (t=%0t)",
                         shot_row, shot_col, $time);
            end else begin
                got = expq.pop_front();
                check("shot_row", int'(shot_row), got.row);
                check("shot_col", int'(shot_col), got.col);
                check("shot_player", int'(shot_player), got.player);
                transfers++;
            end
        end
    end

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; shot_ready = 1'b0;
        @(posedge clock27);
        #1;
        doReset(1'b0);

        // Basic shot with break codes interleaved, ready held high.
        sendKey(8'h1C, 1); sendKey(8'hF0, 1); sendKey(8'h1C, 1);
        sendKey(8'h16, 1); sendKey(8'hF0, 1); sendKey(8'h16, 1);
        sendKey(8'h5A, 1); sendKey(8'hF0, 1); sendKey(8'h5A, 1);
        idleCycles(2, 1);
        check("turn after first shot", int'(player_turn), 1);

        // Shot held by a stalled decider, with keys ignored meanwhile.
        sendKey(8'h3B, 0); sendKey(8'h46, 0); sendKey(8'h5A, 0);
        idleCycles(10, 0);
        sendKey(8'h1C, 0); sendKey(8'h16, 0); sendKey(8'h5A, 0);
        idleCycles(8, 0);
        idleCycles(3, 1);

        // Out-of-sequence keys.
        sendKey(8'h16, 1); sendKey(8'h32, 1); sendKey(8'h5A, 1);
        sendKey(8'h66, 1); idleCycles(1, 1);

        // Backspace then correction.
        sendKey(8'h32, 1); sendKey(8'h1E, 1); sendKey(8'h66, 1);
        sendKey(8'h26, 1); sendKey(8'h5A, 1); idleCycles(2, 1);

        // Keypad Enter fires, E0 F0 5A does not.
        sendKey(8'h21, 1); sendKey(8'h45, 1); sendKey(8'hE0, 1); sendKey(8'h5A, 1);
        idleCycles(2, 1);
        sendKey(8'h21, 1); sendKey(8'h45, 1); sendKey(8'hE0, 1); sendKey(8'hF0, 1); sendKey(8'h5A, 1);
        idleCycles(2, 1);
        sendKey(8'h66, 1); sendKey(8'h66, 1);

        // Reset while a shot is outstanding drops it.
        sendKey(8'h3B, 0); sendKey(8'h46, 0); sendKey(8'h5A, 0);
        idleCycles(3, 0);
        doReset(1'b0);
        idleCycles(3, 0);
        idleCycles(3, 1);
        check("transfers after reset", transfers, expected_transfers - 1);

        // Randomized keystreams, including back-to-back bytes and a stalling decider.
        for (int i = 0; i < 3000; i++) begin
            bit         kv  = ($urandom_range(0, 3) != 0);
            bit         rdy = ($urandom_range(0, 2) != 0);
            logic [7:0] c;
            c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
            applyStimulus(kv, c, rdy);
        end
        idleCycles(4, 1);

        check("scoreboard drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_entry.md
# shot_entry

Keyboard-to-game front end for Battleship. It consumes PS/2 set-2 scan-code bytes from the keyboard receiver and assembles a target coordinate: a letter A–J for the row and a digit 0–9 for the column, confirmed with Enter. It presents the completed shot to the board-update/decider stage over a valid/ready handshake and owns the player-turn bit that the VGA and HEX controllers display.

## Interface
Parameters:
- BOARD_SIZE, 10, rows/columns per board; only 10 is supported.
- ENTER_CODE, 8'h5A, make code that confirms a shot.
- BKSP_CODE, 8'h66, make code that deletes the last accepted field.

Ports:
- clock27  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  synchronous, active-high.
- key_valid  in  1  one-cycle strobe marking a new byte on key_code.
- key_code  in  8  received scan-code byte.
- shot_ready  in  1  decider can accept a shot.
- shot_valid  out  1  a complete shot is presented.
- shot_row  out  4  row index 0–9 (A=0 … J=9); meaningful while shot_valid=1.
- shot_col  out  4  column index 0–9.
- shot_player  out  1  player firing the shot (0 = player one).
- player_turn  out  1  current player; feeds display controllers.
- pend_row  out  4  row being typed, for HEX display.
- pend_col  out  4  column being typed, for HEX display.
- pend_flags  out  2  {col_entered, row_entered}.
- key_err  out  1  one-cycle pulse on an out-of-sequence key.

## Operation
- Prefix handling runs before the FSM:
  - F0 sets break_skip; the next byte is discarded and break_skip clears.
  - E0 sets ext; the next non-F0 byte clears ext and is ignored unless it is 5A (keypad Enter), which counts as Enter.
  - E0 F0 xx is discarded entirely.
- Letter map (row 0–9): 1C,32,21,23,24,2B,34,33,43,3B.
- Digit map (col 0–9): 45,16,1E,26,25,2E,36,3D,3E,46.
- Any other byte is ignored silently and causes no state change.
- FSM states: IDLE, HAVE_ROW, HAVE_BOTH, SEND.
  - IDLE: letter → latch pend_row, go to HAVE_ROW. Digit or Enter → key_err. BKSP → no-op.
  - HAVE_ROW: letter → replace pend_row. Digit → latch pend_col, go to HAVE_BOTH. Enter → key_err. BKSP → IDLE, pend_row=0.
  - HAVE_BOTH: letter → new pend_row, pend_col=0, go to HAVE_ROW. Digit → replace pend_col. BKSP → HAVE_ROW, pend_col=0. Enter → load shot_row/col/player from pend_*/player_turn, go to SEND.
  - SEND: all key bytes are ignored (prefix tracking continues). When shot_valid & shot_ready: toggle player_turn, clear pend_*, go to IDLE.
- pend_flags = 00 in IDLE, 01 in HAVE_ROW, 11 in HAVE_BOTH and SEND.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, break_skip=ext=0, and player_turn=0.
- A byte is consumed on the edge where key_valid=1. Resulting pend_*, pend_flags and key_err are visible the next cycle. key_err lasts exactly one cycle.
- Enter accepted on edge N: shot_valid=1 from cycle N+1, with shot_* stable until the transfer.
- Transfer happens on the first edge with shot_valid & shot_ready. On that edge player_turn toggles; shot_valid=0 the following cycle.
- shot_ready may be high continuously, giving a 1-cycle valid pulse. shot_ready low holds shot_valid indefinitely.
- shot_valid never depends combinationally on shot_ready.
- key_valid in the same cycle as a transfer: the byte is ignored, because SEND is still the current state.
- Reset mid-SEND drops the shot with no transfer and returns player_turn to 0.
- Back-to-back key_valid on consecutive cycles is supported, one byte per cycle.

## Test plan
- Reset, then feed 1C, F0, 1C, 16, F0, 16, 5A, F0, 5A with shot_ready=1. Required: shot_valid one cycle with row=0, col=1, shot_player=0; player_turn becomes 1; pend_flags returns to 00.
- Feed 3B, 46, 5A with shot_ready=0 for 20 cycles, then 1. Required: shot_valid held 20+ cycles with row=9, col=9; additional keys during the hold are ignored; one transfer occurs; player_turn toggles once.
- Feed 16 in IDLE, then 5A in HAVE_ROW (after 32). Required: a key_err pulse each time and no state change; pend_row=1 after 32.
- Feed 32, 1E, 66, 26, 5A. Required: after BKSP, pend_flags=01; the final shot is row=1, col=3.
- Feed 21, 45, E0, 5A. Required: keypad Enter fires a shot with row=2, col=0. Feeding 21, 45, E0, F0, 5A instead must fire no shot.
- Assert reset while in SEND with shot_ready=0. Required: the next cycle has shot_valid=0, player_turn=0, pend_flags=00, and no transfer is ever observed.
